instr_decode_ctrl: RTL

//  Instruction-driven controller for the regfile/ALU datapath. It accepts 16-bit instruction words over a

---
 rtl/instr_decode_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: accepts 16-bit instruction words over valid/ready and
// drives the regfile/ALU control bundle for one execute cycle per word.
// Every output is registered; the bundle is decoded from the incoming word
// and captured on the accept edge, so it is valid for the whole EXEC cycle.
module instr_decode_ctrl #(
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rs,
    output logic [3:0]  rd,
    output logic [4:0]  opcode,
    output logic [15:0] re,
    output logic        ri,
    output logic        fe,
    output logic [15:0] imm,
    output logic [15:0] retired,
    output logic        err,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [4:0] OPCODE_RST = 5'b00101;

    state_t      state_q;
    logic [15:0] ir_q;
    logic        ready_q;
    logic [3:0]  rs_q, rd_q;
    logic [4:0]  opcode_q;
    logic [15:0] re_q;
    logic        ri_q, fe_q;
    logic [15:0] imm_q;
    logic [15:0] retired_q;
    logic        err_q, halted_q;

    // Decoded bundle for the word currently on the instr input
    logic [3:0]  rs_d, rd_d;
    logic [4:0]  opcode_d;
    logic [15:0] re_d;
    logic        ri_d, fe_d;
    logic [15:0] imm_d;

    // R-type ext and I-type op share the same legal code set
    function automatic logic code_legal(input logic [3:0] c);
        case (c)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: code_legal = 1'b1;
            default:                                  code_legal = 1'b0;
        endcase
    endfunction

    // Legality of a whole word; the NOP word retires even though its code is not in the set
    function automatic logic word_legal(input logic [15:0] w);
        if (w == NOP_WORD)
            word_legal = 1'b1;
        else if (w[15:12] == 4'h0)
            word_legal = code_legal(w[7:4]);
        else
            word_legal = code_legal(w[15:12]);
    endfunction

    // Arithmetic immediates (ADDI/SUBI/CMPI/MOVI) sign-extend, logical ones zero-extend
    function automatic logic [15:0] ext_imm(input logic [3:0] op, input logic [7:0] imm8);
        logic signed [7:0]  s8;
        logic signed [15:0] s16;
        s8  = imm8;
        s16 = s8;
        case (op)
            4'h5, 4'h9, 4'hB, 4'hD: ext_imm = s16;
            default:                ext_imm = {8'h00, imm8};
        endcase
    endfunction

    // Combinational decode of the incoming word into the next control bundle
    always_comb begin
        logic [3:0] code;
        logic       legal;
        logic       nop;
        rd_d     = instr[11:8];
        rs_d     = instr[3:0];
        opcode_d = {1'b0, instr[7:4]};
        ri_d     = 1'b0;
        imm_d    = 16'h0000;
        code     = instr[7:4];
        if (instr[15:12] != 4'h0) begin
            rs_d     = instr[11:8];
            opcode_d = {1'b0, instr[15:12]};
            ri_d     = 1'b1;
            imm_d    = ext_imm(instr[15:12], instr[7:0]);
            code     = instr[15:12];
        end
        nop   = (instr == NOP_WORD);
        legal = word_legal(instr);
        re_d  = 16'h0000;
        fe_d  = 1'b0;
        if (legal && !nop) begin
            if (code != 4'hB)
                re_d = 16'h0001 << instr[11:8];
            fe_d = (code == 4'h5) || (code == 4'h9) || (code == 4'hB);
        end
    end

    // Controller FSM with registered control bundle and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ir_q      <= NOP_WORD;
            ready_q   <= 1'b1;
            rs_q      <= 4'h0;
            rd_q      <= 4'h0;
            opcode_q  <= OPCODE_RST;
            re_q      <= 16'h0000;
            ri_q      <= 1'b0;
            fe_q      <= 1'b0;
            imm_q     <= 16'h0000;
            retired_q <= 16'h0000;
            err_q     <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (instr == HALT_WORD) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q  <= EXEC;
                            ir_q     <= instr;
                            rs_q     <= rs_d;
                            rd_q     <= rd_d;
                            opcode_q <= opcode_d;
                            re_q     <= re_d;
                            ri_q     <= ri_d;
                            fe_q     <= fe_d;
                            imm_q    <= imm_d;
                        end
                    end
                end
                EXEC: begin
                    re_q    <= 16'h0000;
                    fe_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                    if (word_legal(ir_q))
                        retired_q <= retired_q + 16'd1;
                    else
                        err_q <= 1'b1;
                end
                HALT: begin
                    re_q    <= 16'h0000;
                    fe_q    <= 1'b0;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    re_q    <= 16'h0000;
                    fe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign rs          = rs_q;
    assign rd          = rd_q;
    assign opcode      = opcode_q;
    assign re          = re_q;
    assign ri          = ri_q;
    assign fe          = fe_q;
    assign imm         = imm_q;
    assign retired     = retired_q;
    assign err         = err_q;
    assign halted      = halted_q;

endmodule
